// File: rtl/move_recorder.sv
// Move recorder: five debounced buttons build a packed sequence of 2-bit moves.
// Each button is synchronized, debounced and rising-edge detected. At most one action
// is taken per cycle, in the order UNDO > UP > DOWN > LEFT > RIGHT.
module move_recorder #(
  parameter int unsigned DEB_CYCLES = 1000,
  parameter int unsigned MAX_MOVES  = 22
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [4:0]             i_btn,
  input  logic                   i_clr,
  input  logic                   i_lock,
  output logic [2*MAX_MOVES-1:0] o_ord,
  output logic [2*MAX_MOVES-1:0] o_cnt,
  output logic                   o_full,
  output logic                   o_evt,
  output logic                   o_ovf
);

  localparam int unsigned OW = 2 * MAX_MOVES;
  localparam int unsigned CW = $clog2(MAX_MOVES + 1);
  localparam int unsigned DW = $clog2(DEB_CYCLES + 2);
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_MOVES);
  localparam logic [DW-1:0] DebMax = DW'(DEB_CYCLES);

  logic [4:0]    r_sync1, r_sync2, r_stable, r_stable_prev;
  logic [DW-1:0] r_deb [5];
  logic [OW-1:0] r_ord;
  logic [CW-1:0] r_cnt;
  logic          r_full, r_evt, r_ovf;

  logic [4:0]    w_press;
  logic [1:0]    w_code;
  logic [OW-1:0] w_ord_d;
  logic [CW-1:0] w_cnt_d;
  logic          w_evt_d, w_ovf_d;

  // Synchronize raw buttons, then debounce each one with its own hold counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_stable      <= '0;
      r_stable_prev <= '0;
      for (int i = 0; i < 5; i++) r_deb[i] <= '0;
    end else begin
      r_sync1       <= i_btn;
      r_sync2       <= r_sync1;
      r_stable_prev <= r_stable;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_deb[i] <= '0;
        end else if (r_deb[i] == DebMax) begin
          r_stable[i] <= r_sync2[i];
          r_deb[i]    <= '0;
        end else begin
          r_deb[i] <= r_deb[i] + DW'(1);
        end
      end
    end
  end

  assign w_press = r_stable & ~r_stable_prev;

  // Pick the single action for this cycle; clr overrides everything, lock drops presses.
  always_comb begin
    w_ord_d = r_ord;
    w_cnt_d = r_cnt;
    w_evt_d = 1'b0;
    w_ovf_d = 1'b0;
    w_code  = 2'b00;
    if (w_press[0])      w_code = 2'b01;
    else if (w_press[1]) w_code = 2'b10;
    else if (w_press[2]) w_code = 2'b11;
    if (i_clr) begin
      w_ord_d = '0;
      w_cnt_d = '0;
    end else if (!i_lock) begin
      if (w_press[4]) begin
        // Undo on an empty sequence still consumes the cycle's lower-priority presses.
        if (r_cnt != '0) begin
          w_cnt_d                = r_cnt - CW'(1);
          w_ord_d[2*w_cnt_d +: 2] = 2'b00;
          w_evt_d                = 1'b1;
        end
      end else if (|w_press[3:0]) begin
        if (r_cnt == MaxCnt) begin
          w_ovf_d = 1'b1;
        end else begin
          w_ord_d[2*r_cnt +: 2] = w_code;
          w_cnt_d               = r_cnt + CW'(1);
          w_evt_d               = 1'b1;
        end
      end
    end
  end

  // Sequence state and registered status pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ord  <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
      r_evt  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_ord  <= w_ord_d;
      r_cnt  <= w_cnt_d;
      r_full <= (w_cnt_d == MaxCnt);
      r_evt  <= w_evt_d;
      r_ovf  <= w_ovf_d;
    end
  end

  assign o_ord  = r_ord;
  assign o_cnt  = OW'(r_cnt);
  assign o_full = r_full;
  assign o_evt  = r_evt;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_move_recorder.sv
// Bench for move_recorder: a queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_move_recorder;

  localparam int D   = 4;
  localparam int MAX = 22;
  localparam int OW  = 2 * MAX;

  logic          clk = 1'b0;
  logic          rst, clr, lock;
  logic [4:0]    btn;
  logic [OW-1:0] ord, cnt;
  logic          full, evt, ovf;

  move_recorder #(.DEB_CYCLES(D), .MAX_MOVES(MAX)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_btn (btn),
    .i_clr (clr),
    .i_lock(lock),
    .o_ord (ord),
    .o_cnt (cnt),
    .o_full(full),
    .o_evt (evt),
    .o_ovf (ovf)
  );

  always #5 clk = ~clk;

  int vecs  = 0;
  int fails = 0;
  int n_evt = 0;
  int n_ovf = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: moves held in a queue, buttons tracked as "value must persist for
  // D+1 synchronized cycles before it is accepted".
  int         m_q[$];
  logic [4:0] m_s1, m_s2, m_stab, m_prev, m_pr;
  int         m_streak[5];
  bit         m_evt, m_ovf, m_valid = 0;
  int         m_code;
  logic [OW-1:0] m_ord;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_prev = '0;
      for (int b = 0; b < 5; b++) m_streak[b] = 0;
      m_evt = 0; m_ovf = 0; m_valid = 1;
    end else begin
      m_pr  = m_stab & ~m_prev;
      m_evt = 0;
      m_ovf = 0;
      if (clr) begin
        m_q.delete();
      end else if (!lock) begin
        if (m_pr[4]) begin
          if (m_q.size() > 0) begin
            void'(m_q.pop_back());
            m_evt = 1;
          end
        end else if (m_pr[3:0] != 0) begin
          m_code = m_pr[0] ? 1 : m_pr[1] ? 2 : m_pr[2] ? 3 : 0;
          if (m_q.size() == MAX) m_ovf = 1;
          else begin
            m_q.push_back(m_code);
            m_evt = 1;
          end
        end
      end
      m_prev = m_stab;
      for (int b = 0; b < 5; b++) begin
        if (m_s2[b] != m_stab[b]) begin
          m_streak[b]++;
          if (m_streak[b] == D + 1) begin
            m_stab[b]   = m_s2[b];
            m_streak[b] = 0;
          end
        end else m_streak[b] = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
    #1;
    if (m_valid) begin
      m_ord = '0;
      foreach (m_q[i]) m_ord[2*i +: 2] = 2'(m_q[i]);
      check("model_ord", 64'(ord), 64'(m_ord));
      check("model_cnt", 64'(cnt), 64'(m_q.size()));
      check("model_full", 64'(full), 64'(m_q.size() == MAX));
      check("model_evt", 64'(evt), 64'(m_evt));
      check("model_ovf", 64'(ovf), 64'(m_ovf));
      if (evt) n_evt++;
      if (ovf) n_ovf++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] m);
    btn = btn | m;
    tick(D + 4);
    btn = btn & ~m;
    tick(D + 8);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  // Edges from the current negedge until the first evt pulse, bounded by limit.
  task automatic wait_evt(output int edges, input int limit);
    edges = 0;
    while (edges < limit) begin
      @(posedge clk);
      #1;
      edges++;
      if (evt) break;
    end
    if (!evt) edges = -1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vecs, fails);
    $fatal(1, "watchdog");
  end

  int e, n0, o0;

  initial begin
    rst = 1'b1; clr = 1'b0; lock = 1'b0; btn = '0;
    tick(3);
    rst = 1'b0;
    check("reset_cnt", 64'(cnt), 64'd0);
    check("reset_ord", 64'(ord), 64'd0);
    check("reset_full", 64'(full), 64'd0);

    // UP then LEFT; first event exactly D+4 edges after the press is first sampled.
    n0 = n_evt;
    btn[0] = 1'b1;
    wait_evt(e, 20);
    check("up_latency", 64'(e), 64'd8);
    tick(D);
    btn[0] = 1'b0;
    tick(D + 8);
    press(5'b00100);
    check("ul_cnt", 64'(cnt), 64'd2);
    check("ul_ord", 64'(ord[3:0]), 64'b1101);
    check("ul_evts", 64'(n_evt - n0), 64'd2);

    // Short glitch is rejected; a long hold produces exactly one event.
    do_clr();
    n0 = n_evt;
    btn[1] = 1'b1;
    tick(3);
    btn[1] = 1'b0;
    tick(15);
    check("glitch_evts", 64'(n_evt - n0), 64'd0);
    check("glitch_cnt", 64'(cnt), 64'd0);
    btn[1] = 1'b1;
    tick(20);
    btn[1] = 1'b0;
    tick(15);
    check("hold_evts", 64'(n_evt - n0), 64'd1);
    check("hold_ord", 64'(ord[1:0]), 64'b10);

    // Undo behaviour, including undo on an empty sequence.
    do_clr();
    press(5'b00001);
    press(5'b00010);
    press(5'b10000);
    check("undo1_cnt", 64'(cnt), 64'd1);
    check("undo1_ord", 64'(ord), 64'h1);
    press(5'b10000);
    check("undo2_cnt", 64'(cnt), 64'd0);
    check("undo2_ord", 64'(ord), 64'h0);
    n0 = n_evt; o0 = n_ovf;
    press(5'b10000);
    check("undo_empty_evt", 64'(n_evt - n0), 64'd0);
    check("undo_empty_ovf", 64'(n_ovf - o0), 64'd0);

    // Simultaneous UP+UNDO, lock behaviour, clr overriding a pending event.
    do_clr();
    repeat (3) press(5'b00001);
    n0 = n_evt;
    press(5'b10001);
    check("prio_cnt", 64'(cnt), 64'd2);
    check("prio_ord", 64'(ord), 64'h5);
    check("prio_evts", 64'(n_evt - n0), 64'd1);
    lock = 1'b1;
    n0 = n_evt; o0 = n_ovf;
    press(5'b00010);
    press(5'b10000);
    btn[1] = 1'b1;
    tick(D + 6);
    lock = 1'b0;
    tick(4);
    btn[1] = 1'b0;
    tick(D + 8);
    check("lock_cnt", 64'(cnt), 64'd2);
    check("lock_evts", 64'(n_evt - n0), 64'd0);
    check("lock_ovf", 64'(n_ovf - o0), 64'd0);
    n0 = n_evt;
    btn[3] = 1'b1;
    tick(6);
    clr = 1'b1;
    tick(3);
    clr = 1'b0;
    btn[3] = 1'b0;
    tick(D + 8);
    check("clr_cnt", 64'(cnt), 64'd0);
    check("clr_evts", 64'(n_evt - n0), 64'd0);

    // Fill with RIGHT, then one more direction overflows.
    repeat (MAX) press(5'b01000);
    check("fill_cnt", 64'(cnt), 64'd22);
    check("fill_full", 64'(full), 64'd1);
    check("fill_ord", 64'(ord), 64'd0);
    n0 = n_evt; o0 = n_ovf;
    press(5'b00001);
    check("ovf_pulses", 64'(n_ovf - o0), 64'd1);
    check("ovf_evts", 64'(n_evt - n0), 64'd0);
    check("ovf_cnt", 64'(cnt), 64'd22);

    // Reset in the middle of a debounce, button still held afterwards.
    btn[0] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(2);
    check("mid_rst_cnt", 64'(cnt), 64'd0);
    check("mid_rst_full", 64'(full), 64'd0);
    check("mid_rst_evt", 64'(evt), 64'd0);
    rst = 1'b0;
    wait_evt(e, 20);
    check("post_rst_latency", 64'(e), 64'd8);
    btn[0] = 1'b0;
    tick(D + 8);
    check("post_rst_ord", 64'(ord), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
